imm_encoder: RTL and testbench
==============================

# imm_encoder

Streaming immediate encoder: takes a 32-bit immediate value, a format select and a base instruction word, and produces the instruction word with the immediate placed into the format's bit fields. It is the inverse of the core's immediate extender and uses the same select encoding. Feeding `out_instr` and the same select through the extender returns `in_imm` whenever `out_err` is 0. It sits in the instruction-generation/self-test path ahead of instruction memory load, with valid/ready handshakes on both sides and a registered, skid-buffered output.

## Interface
- `CNT_W`, default 16: width of the saturating word and error counters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: block can accept an input this cycle.
- `in_imm` input 32: immediate value, two's complement.
- `in_select` input 3: format. 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 invalid.
- `in_base` input 32: instruction word supplying all non-immediate bits (opcode, rd, funct3, rs1, rs2, funct7).
- `out_valid` output 1: output word valid.
- `out_ready` input 1: consumer accepts the output this cycle.
- `out_instr` output 32: encoded instruction.
- `out_err` output 1: the immediate was not representable, or the select was invalid.
- `cnt_clr` input 1: synchronous clear of both counters.
- `word_count` output CNT_W: accepted inputs, saturating.
- `err_count` output CNT_W: accepted inputs with an error, saturating.

## Operation
- Encode masks clear the immediate field bits of `in_base`. The immediate bits are then ORed in:
  - I: [31:20] = imm[11:0].
  - S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
  - B: [31] = imm[12]; [30:25] = imm[10:5]; [11:8] = imm[4:1]; [7] = imm[11].
  - J: [31] = imm[20]; [30:21] = imm[10:1]; [20] = imm[11]; [19:12] = imm[19:12].
  - U: [31:12] = imm[31:12].
  - Invalid select: `out_instr` = `in_base` unchanged.
- Error rules (`out_err` = 1):
  - I and S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0] = 1.
  - J: imm[31:20] not all equal, or imm[0] = 1.
  - U: imm[11:0] not equal to 0.
  - Any invalid select.
- An erroneous word is still emitted, with the truncated field bits placed as listed above. It is never dropped.
- Buffering: one output register plus one skid register (two entries total). Output order is strictly the input acceptance order.
- `in_ready` = skid register empty. It is a registered signal, with no combinational path from `out_ready`.
- Accept occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Accept with the output register empty, or with the output register transferring this cycle: the word goes to the output register.
- Accept otherwise: the word goes to the skid register.
- When the output transfers and the skid register is full: skid moves to output and the skid register empties.
- Counters: on accept, `word_count` increments, and `err_count` increments if the word has an error. Both hold at 2^CNT_W−1.
- `cnt_clr` zeroes both counters and takes priority over a simultaneous increment. It does not affect the data path.

## Timing
- Reset values:
  - `out_valid` = 0, `out_instr` = 0, `out_err` = 0.
  - `in_ready` = 1.
  - Both counters = 0.
  - Both buffers empty.
- Reset assertion mid-operation discards buffered words immediately, asynchronously.
- Latency: a word accepted at edge N appears with `out_valid` = 1 after edge N, if the output register is empty or draining.
- Throughput: one word per cycle while `out_ready` = 1.
- `out_instr` and `out_err` hold stable while `out_valid && !out_ready`.
- With `out_ready` = 0: two words are accepted, then `in_ready` = 0 after the second accept edge.
- When `out_ready` = 1 at a full-buffer edge, `in_ready` returns to 1 after that edge.
- `word_count` and `err_count` update on the accept edge and are visible the following cycle.

## Test plan
- I-type imm 0xFFFFFFFF, base 0x00000013 → `out_instr` 0xFFF00013, `out_err` 0, one cycle after accept.
- S-type imm 0xFFFFFFFC, base 0x00002023 → 0xFE002E23. B-type imm 0x00000800, base 0x00000063 → 0x000000E3. U-type imm 0x12345000, base 0x00000037 → 0x12345037.
- J-type imm 0x00000001, base 0x0000006F → `out_err` 1 and `err_count` increments. Select 110 with base 0xDEADBEEF → `out_instr` 0xDEADBEEF, `out_err` 1.
- Backpressure: `out_ready` = 0 while driving 3 words.
  - Only 2 are accepted and `in_ready` = 0.
  - The output holds word 1.
  - After `out_ready` = 1, words come out in order, one per cycle.
- Round-trip: random imm/select within legal ranges → extender(`out_instr`, select) == imm and non-immediate bits equal `in_base`, over ≥10k words.
- Counters:
  - With CNT_W = 4, 20 accepts → `word_count` saturates at 15.
  - `cnt_clr` together with an accept → 0.
  - `rst_n` low mid-stream → `out_valid` 0 immediately and `in_ready` 1.

Source files
------------

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: places a 32-bit immediate into the I/S/B/J/U
// bit fields of a base instruction word, behind a two-entry skid-buffered output.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_select,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    logic [31:0]      w_mask;
    logic [31:0]      w_field;
    logic [31:0]      w_instr;
    logic             w_err;
    logic             w_accept;
    logic             w_xfer;

    logic             r_outValid;
    logic [31:0]      r_outInstr;
    logic             r_outErr;
    logic             r_skidValid;
    logic [31:0]      r_skidInstr;
    logic             r_skidErr;
    logic [CNT_W-1:0] r_wordCount;
    logic [CNT_W-1:0] r_errCount;

    // Field mask, placed immediate bits and representability per format
    always_comb begin
        w_mask  = '0;
        w_field = '0;
        w_err   = 1'b0;
        case (in_select)
            3'b000: begin
                w_mask  = 32'hFFF0_0000;
                w_field = {in_imm[11:0], 20'b0};
                w_err   = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            3'b001: begin
                w_mask  = 32'hFE00_0F80;
                w_field = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                w_err   = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            end
            3'b010: begin
                w_mask  = 32'hFE00_0F80;
                w_field = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
                w_err   = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
            end
            3'b011: begin
                w_mask  = 32'hFFFF_F000;
                w_field = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
                w_err   = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
            end
            3'b100: begin
                w_mask  = 32'hFFFF_F000;
                w_field = {in_imm[31:12], 12'b0};
                w_err   = |in_imm[11:0];
            end
            default: begin
                w_err   = 1'b1;
            end
        endcase
    end

    assign w_instr  = (in_base & ~w_mask) | w_field;
    assign w_accept = in_valid && !r_skidValid;
    assign w_xfer   = r_outValid && out_ready;

    // The skid register only fills while the output is stalled, so an accept
    // never coincides with a skid-to-output move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid  <= 1'b0;
            r_outInstr  <= '0;
            r_outErr    <= 1'b0;
            r_skidValid <= 1'b0;
            r_skidInstr <= '0;
            r_skidErr   <= 1'b0;
        end else if (w_accept && (!r_outValid || w_xfer)) begin
            r_outValid  <= 1'b1;
            r_outInstr  <= w_instr;
            r_outErr    <= w_err;
        end else if (w_accept) begin
            r_skidValid <= 1'b1;
            r_skidInstr <= w_instr;
            r_skidErr   <= w_err;
        end else if (w_xfer) begin
            if (r_skidValid) begin
                r_outInstr  <= r_skidInstr;
                r_outErr    <= r_skidErr;
                r_skidValid <= 1'b0;
            end else begin
                r_outValid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wordCount <= '0;
            r_errCount  <= '0;
        end else if (cnt_clr) begin
            r_wordCount <= '0;
            r_errCount  <= '0;
        end else if (w_accept) begin
            if (r_wordCount != {CNT_W{1'b1}}) begin
                r_wordCount <= r_wordCount + 1'b1;
            end
            if (w_err && (r_errCount != {CNT_W{1'b1}})) begin
                r_errCount <= r_errCount + 1'b1;
            end
        end
    end

    assign in_ready   = !r_skidValid;
    assign out_valid  = r_outValid;
    assign out_instr  = r_outInstr;
    assign out_err    = r_outErr;
    assign word_count = r_wordCount;
    assign err_count  = r_errCount;

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized bench for imm_encoder: a queue-based reference model tracks the
// words held in the block, plus directed format, backpressure, counter and reset cases.
module tb_imm_encoder;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_imm;
    logic [2:0]       in_select;
    logic [31:0]      in_base;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic             cnt_clr;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] err_count;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [31:0] base;
    } word_t;

    word_t q[$];
    int    expWords;
    int    expErrs;
    int    vectorCount;
    int    missCount;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_select(in_select), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .cnt_clr(cnt_clr), .word_count(word_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Immediate bits of each format, as a bit-position list of the field layout
    function automatic logic [31:0] immMask(input logic [2:0] sel);
        case (sel)
            3'd0:    return 32'hFFF0_0000;
            3'd1:    return 32'hFE00_0F80;
            3'd2:    return 32'hFE00_0F80;
            3'd3:    return 32'hFFFF_F000;
            3'd4:    return 32'hFFFF_F000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] encodeRef(input logic [31:0] imm, input logic [2:0] sel, input logic [31:0] base);
        logic [31:0] w;
        w = base & ~immMask(sel);
        case (sel)
            3'd0: w[31:20] = imm[11:0];
            3'd1: begin w[31:25] = imm[11:5]; w[11:7] = imm[4:0]; end
            3'd2: begin w[31] = imm[12]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1]; w[7] = imm[11]; end
            3'd3: begin w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12]; end
            3'd4: w[31:12] = imm[31:12];
            default: ;
        endcase
        return w;
    endfunction

    // Representability by numeric range rather than bit patterns
    function automatic logic errRef(input logic [31:0] imm, input logic [2:0] sel);
        int signed v;
        v = imm;
        case (sel)
            3'd0, 3'd1: return (v < -2048) || (v > 2047);
            3'd2:       return (v < -4096) || (v > 4095) || (v % 2 != 0);
            3'd3:       return (v < -1048576) || (v > 1048575) || (v % 2 != 0);
            3'd4:       return (imm % 4096) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] extendRef(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4:    return {i[31:12], 12'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] legalImm(input logic [2:0] sel);
        logic [31:0] r;
        r = $urandom;
        case (sel)
            3'd0, 3'd1: return {{20{r[11]}}, r[11:0]};
            3'd2:       return {{19{r[12]}}, r[12:1], 1'b0};
            3'd3:       return {{11{r[20]}}, r[20:1], 1'b0};
            3'd4:       return {r[31:12], 12'b0};
            default:    return r;
        endcase
    endfunction

    task automatic checkState();
        checkOutput("in_ready", 32'(in_ready), 32'(q.size() < 2));
        checkOutput("out_valid", 32'(out_valid), 32'(q.size() > 0));
        checkOutput("word_count", 32'(word_count), 32'(expWords));
        checkOutput("err_count", 32'(err_count), 32'(expErrs));
        if (q.size() > 0) begin
            checkOutput("out_instr", out_instr, q[0].instr);
            checkOutput("out_err", 32'(out_err), 32'(q[0].err));
            if (!q[0].err) begin
                checkOutput("roundtrip", extendRef(out_instr, q[0].sel), q[0].imm);
                checkOutput("base_bits", out_instr & ~immMask(q[0].sel), q[0].base & ~immMask(q[0].sel));
            end
        end
    endtask

    // One cycle: check at the falling edge, drive, then advance the model on the rising edge
    task automatic stepCycle(input logic v, input logic [31:0] imm, input logic [2:0] sel,
                             input logic [31:0] base, input logic rdy, input logic clr);
        word_t w;
        logic  acc;
        logic  xfer;
        checkState();
        in_valid  = v;
        in_imm    = imm;
        in_select = sel;
        in_base   = base;
        out_ready = rdy;
        cnt_clr   = clr;
        acc  = v && (q.size() < 2);
        xfer = rdy && (q.size() > 0);
        @(posedge clk);
        if (xfer) void'(q.pop_front());
        if (acc) begin
            w.instr = encodeRef(imm, sel, base);
            w.err   = errRef(imm, sel);
            w.imm   = imm;
            w.sel   = sel;
            w.base  = base;
            q.push_back(w);
        end
        if (clr) begin
            expWords = 0;
            expErrs  = 0;
        end else if (acc) begin
            if (expWords < CNT_MAX) expWords++;
            if (w.err && expErrs < CNT_MAX) expErrs++;
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] imm, input logic [2:0] sel,
                                 input logic [31:0] base, input logic [31:0] expInstr, input logic expErr);
        stepCycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        stepCycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        stepCycle(1'b1, imm, sel, base, 1'b1, 1'b0);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_instr"}, out_instr, expInstr);
        checkOutput({tag, "_err"}, 32'(out_err), 32'(expErr));
    endtask

    initial begin
        logic [2:0]  sel;
        logic [31:0] imm;
        int          s;
        vectorCount = 0;
        missCount   = 0;
        expWords    = 0;
        expErrs     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_select = '0;
        in_base   = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_err", 32'(out_err), 32'h0);
        checkState();
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("I", 32'hFFFF_FFFF, 3'd0, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        applyStimulus("S", 32'hFFFF_FFFC, 3'd1, 32'h0000_2023, 32'hFE00_2E23, 1'b0);
        applyStimulus("B", 32'h0000_0800, 3'd2, 32'h0000_0063, 32'h0000_00E3, 1'b0);
        applyStimulus("U", 32'h1234_5000, 3'd4, 32'h0000_0037, 32'h1234_5037, 1'b0);
        applyStimulus("J", 32'h0000_0001, 3'd3, 32'h0000_006F, 32'h0000_006F, 1'b1);
        stepCycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("J_errcnt", 32'(err_count), 32'd1);
        applyStimulus("SEL6", 32'h0000_0000, 3'd6, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

        // Backpressure: three offered words, two taken, output holds the first
        repeat (2) stepCycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) stepCycle(1'b1, 32'(i), 3'd0, 32'h0000_0013, 1'b0, 1'b0);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_hold", out_instr, 32'h0010_0013);
        stepCycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_second", out_instr, 32'h0020_0013);
        checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
        repeat (2) stepCycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);

        // Counter saturation and clear priority
        stepCycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) stepCycle(1'b1, 32'h0, 3'd0, 32'h13, 1'b1, 1'b0);
        checkOutput("sat_word_count", 32'(word_count), 32'd15);
        stepCycle(1'b1, 32'h0, 3'd7, 32'h13, 1'b1, 1'b1);
        checkOutput("clr_word_count", 32'(word_count), 32'd0);
        checkOutput("clr_err_count", 32'(err_count), 32'd0);

        // Asynchronous reset with both buffers full
        for (int i = 0; i < 3; i++) stepCycle(1'b1, 32'h40, 3'd0, 32'h13, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        expWords = 0;
        expErrs  = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic with varying backpressure
        for (int phase = 0; phase < 3; phase++) begin
            for (int c = 0; c < 8000; c++) begin
                s   = $urandom_range(0, 15);
                sel = (s < 13) ? 3'(s % 5) : 3'(s - 8);
                imm = ($urandom_range(0, 4) != 0) ? legalImm(sel) : $urandom;
                stepCycle($urandom_range(0, 3) != 0, imm, sel, $urandom,
                          (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 199) == 0);
            end
        end
        checkState();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
